bias_relu_drain: RTL and testbench
==================================

# bias_relu_drain

Downstream stage of the matrix-vector multiply. Captures one parallel result vector of OUT_DIM signed words, adds a per-element bias with saturation, optionally applies ReLU, and streams the elements out one per beat over a valid/ready interface. It decouples the wide parallel matmul output from the narrow serial consumer, such as the next layer's input loader or a result FIFO.

## Interface
- DATA_W, default 32: element width, two's-complement signed.
- OUT_DIM, default 1: elements per vector, ≥1.
- RELU_EN, default 1: 1 = clamp negative results to 0; 0 = pass the saturated sum.
- IDX_W, default $clog2(OUT_DIM) with minimum 1: width of out_idx.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  vec_in and bias hold a vector to capture.
- in_ready  out  1  block can accept a vector this cycle.
- vec_in  in  [OUT_DIM-1:0][DATA_W]  matmul result vector.
- bias  in  [OUT_DIM-1:0][DATA_W]  per-element bias; sampled together with vec_in.
- out_valid  out  1  out_data holds a valid element.
- out_ready  in  1  consumer accepts the element.
- out_data  out  DATA_W  processed element.
- out_idx  out  IDX_W  index of the current element, 0..OUT_DIM-1.
- out_last  out  1  high while out_idx == OUT_DIM-1 and out_valid is high.
- vec_count  out  16  number of vectors fully drained; wraps modulo 2^16.

## Operation
- States: IDLE and STREAM.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid, capture all OUT_DIM results into the buffer, set idx = 0 and go to STREAM.
- Per-element arithmetic at capture:
  - s = sign-extend(vec_in[k]) + sign-extend(bias[k]), computed in DATA_W+1 bits.
  - Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If RELU_EN, replace a negative result with 0.
- STREAM:
  - out_valid = 1; out_data = buffer[idx]; out_idx = idx.
  - A beat completes on out_valid && out_ready; the beat then sets idx = idx + 1.
  - On the beat with idx == OUT_DIM-1:
    - vec_count increments.
    - If in_valid is also high the same cycle, capture the new vector, set idx = 0 and stay in STREAM, with no bubble.
    - Otherwise go to IDLE.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready, and it is intended.
- While out_valid && !out_ready:
  - out_data, out_idx and out_last hold stable.
  - The buffer does not change, and vec_in/bias are ignored.
- OUT_DIM == 1: every beat is a last beat, and out_idx is constantly 0.

## Timing
- Reset, asserted at any time including mid-stream:
  - All of the following clear immediately and asynchronously: state = IDLE, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, vec_count = 0.
  - in_ready reads 1 once reset_n deasserts.
  - A partially drained vector is discarded and is not counted.
- Capture edge T (in_valid && in_ready): element 0 appears with out_valid = 1 in cycle T+1.
- With out_ready held high, element k appears in cycle T+1+k.
  - Sustained throughput is one element per cycle.
  - Back-to-back vectors cost OUT_DIM cycles each, with no idle cycle.
- vec_count updates on the edge that completes the last beat, and is visible the following cycle.
- Simultaneous capture and last beat: the completing vector's last element is the one transferred. The next cycle shows the new vector's element 0.

## Test plan
- Basic stream:
  - Stimulus: DATA_W=8, OUT_DIM=4, RELU_EN=1, vec_in={10,-5,100,0}, bias={1,1,1,-3}, out_ready=1.
  - Required: out_data 11, 0, 101, 0 on idx 0..3; out_last only on idx 3; vec_count = 1.
- Saturation:
  - Stimulus: vec_in[0]=120, bias[0]=20; vec_in[1]=-120, bias[1]=-20; RELU_EN=0.
  - Required: out_data 127, then -128.
  - Same stimulus with RELU_EN=1: required 127, then 0.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,0,1,1.
  - Required: out_data/out_idx stable during the low cycles; each element emitted exactly once, in order; in_ready = 0 throughout.
- Back-to-back vectors:
  - Stimulus: in_valid held high with vectors A then B; out_ready = 1.
  - Required: 8 consecutive valid beats (A0..A3, B0..B3) with no bubble; in_ready pulses only on the A3 beat; vec_count = 2.
- Reset mid-operation:
  - Stimulus: assert reset_n = 0 asynchronously after element 1 of a vector.
  - Required: out_valid = 0 and out_data = 0 immediately; vec_count = 0.
  - After release, a new vector streams starting from idx 0.
- Wrap and corner:
  - Stimulus: OUT_DIM=1; drain 65537 vectors.
  - Required: out_last is high on every beat; out_idx = 0 throughout; vec_count = 1 at the end.

Source files
------------

// File: rtl/bias_relu_drain_if.sv
// ---------------------------------------------------------------------------
// bias_relu_drain_if
// Handshake bundle for the bias/ReLU drain stage.
//   Capture side : in_valid, in_ready, vec_in[OUT_DIM][DATA_W], bias[OUT_DIM][DATA_W]
//   Stream side  : out_valid, out_ready, out_data[DATA_W], out_idx[IDX_W], out_last
// Modports:
//   slave  - the drain block itself (accepts vectors, produces the stream)
//   master - the surrounding environment (drives vectors, consumes the stream)
// ---------------------------------------------------------------------------
interface bias_relu_drain_if #(
    parameter int DATA_W  = 32,
    parameter int OUT_DIM = 1,
    parameter int IDX_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
);
    logic                             in_valid;
    logic                             in_ready;
    logic [OUT_DIM-1:0][DATA_W-1:0]   vec_in;
    logic [OUT_DIM-1:0][DATA_W-1:0]   bias;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_W-1:0]                out_data;
    logic [IDX_W-1:0]                 out_idx;
    logic                             out_last;

    modport master (
        output in_valid, vec_in, bias, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, vec_in, bias, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/bias_relu_drain.sv
// ---------------------------------------------------------------------------
// bias_relu_drain
// Captures one parallel matmul result vector, adds a per-element bias with
// saturation, optionally clamps negatives to zero, and streams the elements
// out one per beat.
// Ports:
//   clk       - rising-edge clock
//   reset_n   - asynchronous active-low reset
//   bus       - bias_relu_drain_if.slave (capture handshake + output stream)
//   vec_count - number of fully drained vectors, wraps modulo 2^16
// Parameters: DATA_W (element width), OUT_DIM (elements per vector),
//   RELU_EN (1 = clamp negatives to 0), IDX_W (width of out_idx).
// ---------------------------------------------------------------------------
module bias_relu_drain #(
    parameter int DATA_W  = 32,
    parameter int OUT_DIM = 1,
    parameter int RELU_EN = 1,
    parameter int IDX_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bias_relu_drain_if.slave     bus,
    output logic [15:0]          vec_count
);

    // The buffer is sized to the full index range so every idx value
    // addresses a real entry; entries at or above OUT_DIM stay zero.
    localparam int               BUF_N    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_DIM - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ZERO_W  = {DATA_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Signed add in DATA_W+1 bits, clamp to the DATA_W range, then ReLU.
    // Overflow shows up as the two top bits of the wide sum disagreeing.
    function automatic logic [DATA_W-1:0] sat_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] res;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            res = sum[DATA_W] ? MIN_NEG : MAX_POS;
        end else begin
            res = sum[DATA_W-1:0];
        end
        return ((RELU_EN != 0) && res[DATA_W-1]) ? ZERO_W : res;
    endfunction

    state_t            state_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [DATA_W-1:0] out_data_r;
    logic [IDX_W-1:0]  idx_r;
    logic [15:0]       vec_count_r;
    logic [DATA_W-1:0] buf_r  [BUF_N];
    logic [DATA_W-1:0] proc_s [BUF_N];

    logic              beat_s;
    logic              last_beat_s;
    logic              in_ready_s;
    logic              capture_s;
    logic [IDX_W-1:0]  next_idx_s;

    // Per-element bias/saturate/ReLU of the vector presented at the input.
    for (genvar k = 0; k < BUF_N; k++) begin : g_proc
        if (k < OUT_DIM) begin : g_live
            assign proc_s[k] = sat_add(bus.vec_in[k], bus.bias[k]);
        end else begin : g_pad
            assign proc_s[k] = ZERO_W;
        end
    end

    // Handshake decode; in_ready deliberately follows out_ready on the last
    // beat so a new vector can be taken without a bubble.
    always_comb begin
        beat_s      = out_valid_r && bus.out_ready;
        last_beat_s = beat_s && out_last_r;
        in_ready_s  = (state_r == ST_IDLE) || last_beat_s;
        capture_s   = bus.in_valid && in_ready_s;
        next_idx_s  = idx_r + IDX_ONE;
    end

    // Capture/stream state machine with registered stream outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= ZERO_W;
            idx_r       <= IDX_ZERO;
            vec_count_r <= 16'd0;
            for (int k = 0; k < BUF_N; k++) begin
                buf_r[k] <= ZERO_W;
            end
        end else begin
            if (capture_s) begin
                // Covers both the idle capture and the capture that rides
                // on the last beat of the previous vector.
                for (int k = 0; k < BUF_N; k++) begin
                    buf_r[k] <= proc_s[k];
                end
                out_data_r  <= proc_s[0];
                idx_r       <= IDX_ZERO;
                out_last_r  <= (LAST_IDX == IDX_ZERO);
                out_valid_r <= 1'b1;
                state_r     <= ST_STREAM;
            end else if (last_beat_s) begin
                idx_r       <= IDX_ZERO;
                out_last_r  <= 1'b0;
                out_valid_r <= 1'b0;
                state_r     <= ST_IDLE;
            end else if (beat_s) begin
                idx_r       <= next_idx_s;
                out_data_r  <= buf_r[next_idx_s];
                out_last_r  <= (next_idx_s == LAST_IDX);
            end
            if (last_beat_s) begin
                vec_count_r <= vec_count_r + 16'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = idx_r;
    assign bus.out_last  = out_last_r;
    assign vec_count     = vec_count_r;

endmodule

// File: tb/tb_bias_relu_drain.sv
// ---------------------------------------------------------------------------
// tb_bias_relu_drain
// Three instances: OUT_DIM=4 with ReLU, OUT_DIM=4 without ReLU (sharing the
// same inputs), and OUT_DIM=1 with ReLU. A queue-based reference model
// predicts every output each cycle; directed scenarios plus random traffic.
// ---------------------------------------------------------------------------
module tb_bias_relu_drain;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bias_relu_drain_if #(.DATA_W(W), .OUT_DIM(N)) if_r ();
    bias_relu_drain_if #(.DATA_W(W), .OUT_DIM(N)) if_n ();
    bias_relu_drain_if #(.DATA_W(W), .OUT_DIM(1)) if_c ();
    logic [15:0] cnt_r, cnt_n, cnt_c;

    bias_relu_drain #(.DATA_W(W), .OUT_DIM(N), .RELU_EN(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .bus(if_r.slave), .vec_count(cnt_r));
    bias_relu_drain #(.DATA_W(W), .OUT_DIM(N), .RELU_EN(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .bus(if_n.slave), .vec_count(cnt_n));
    bias_relu_drain #(.DATA_W(W), .OUT_DIM(1), .RELU_EN(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .bus(if_c.slave), .vec_count(cnt_c));

    assign if_n.in_valid  = if_r.in_valid;
    assign if_n.vec_in    = if_r.vec_in;
    assign if_n.bias      = if_r.bias;
    assign if_n.out_ready = if_r.out_ready;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: exact integer sum, clamp, optional ReLU.
    function automatic int ref_elem(input int v, input int b, input bit relu);
        int s;
        s = v + b;
        if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
        if (s < -(1 << (W - 1)))    s = -(1 << (W - 1));
        if (relu && s < 0)          s = 0;
        return s;
    endfunction

    typedef struct { int dr; int dn; int idx; bit last; } exp_t;
    exp_t exp_q[$];
    int   exp_cnt = 0;
    int   log_r[$];
    int   log_n[$];
    int   exp_c[$];
    int   exp_cnt_c = 0;
    int   rdy_mode = 0;

    // Reference model for the OUT_DIM=4 pair, evaluated once per cycle.
    always @(negedge clk) begin
        bit ev, er;
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            ev = (exp_q.size() != 0);
            er = !ev || (if_r.out_ready && exp_q[0].last);
            check("r_valid", if_r.out_valid, ev);
            check("n_valid", if_n.out_valid, ev);
            check("r_in_ready", if_r.in_ready, er);
            check("n_in_ready", if_n.in_ready, er);
            check("r_count", cnt_r, exp_cnt);
            check("n_count", cnt_n, exp_cnt);
            if (ev) begin
                check("r_data", $signed(if_r.out_data), exp_q[0].dr);
                check("n_data", $signed(if_n.out_data), exp_q[0].dn);
                check("r_idx", if_r.out_idx, exp_q[0].idx);
                check("r_last", if_r.out_last, exp_q[0].last);
                check("n_last", if_n.out_last, exp_q[0].last);
            end else begin
                check("r_last_idle", if_r.out_last, 0);
            end
            if (ev && if_r.out_ready) begin
                if (exp_q[0].last) exp_cnt = (exp_cnt + 1) % 65536;
                log_r.push_back($signed(if_r.out_data));
                log_n.push_back($signed(if_n.out_data));
                void'(exp_q.pop_front());
            end
            if (if_r.in_valid && er) begin
                for (int k = 0; k < N; k++) begin
                    e.dr   = ref_elem($signed(if_r.vec_in[k]), $signed(if_r.bias[k]), 1'b1);
                    e.dn   = ref_elem($signed(if_r.vec_in[k]), $signed(if_r.bias[k]), 1'b0);
                    e.idx  = k;
                    e.last = (k == N - 1);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Reference model for the OUT_DIM=1 instance.
    always @(negedge clk) begin
        bit ev, er;
        if (!reset_n) begin
            exp_c.delete();
            exp_cnt_c = 0;
        end else begin
            ev = (exp_c.size() != 0);
            er = !ev || if_c.out_ready;
            check("c_valid", if_c.out_valid, ev);
            check("c_in_ready", if_c.in_ready, er);
            check("c_count", cnt_c, exp_cnt_c);
            if (ev) begin
                check("c_data", $signed(if_c.out_data), exp_c[0]);
                check("c_last", if_c.out_last, 1);
                check("c_idx", if_c.out_idx, 0);
            end
            if (ev && if_c.out_ready) begin
                exp_cnt_c = (exp_cnt_c + 1) % 65536;
                void'(exp_c.pop_front());
            end
            if (if_c.in_valid && er) begin
                exp_c.push_back(ref_elem($signed(if_c.vec_in[0]), $signed(if_c.bias[0]), 1'b1));
            end
        end
    end

    // Random consumer backpressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) if_r.out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a vector and hold it until the handshake edge has passed.
    task automatic send_vec(input logic [N-1:0][W-1:0] v, input logic [N-1:0][W-1:0] b);
        bit hs;
        int n;
        if_r.in_valid = 1'b1;
        if_r.vec_in   = v;
        if_r.bias     = b;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = if_r.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("handshake", hs, 1);
    endtask

    task automatic send_c(input logic [W-1:0] v, input logic [W-1:0] b);
        bit hs;
        int n;
        if_c.in_valid  = 1'b1;
        if_c.vec_in[0] = v;
        if_c.bias[0]   = b;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = if_c.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("c_handshake", hs, 1);
    endtask

    function automatic logic [N-1:0][W-1:0] rand_vec();
        logic [N-1:0][W-1:0] v;
        for (int k = 0; k < N; k++) v[k] = W'($urandom_range(0, 255));
        return v;
    endfunction

    int exp_basic_r[4] = '{11, 0, 101, 0};
    int exp_basic_n[4] = '{11, -4, 101, -3};
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        if_r.in_valid = 1'b0; if_r.vec_in = '0; if_r.bias = '0; if_r.out_ready = 1'b0;
        if_c.in_valid = 1'b0; if_c.vec_in = '0; if_c.bias = '0; if_c.out_ready = 1'b0;

        // Reset state
        wait_cycles(3);
        check("rst_valid", if_r.out_valid, 0);
        check("rst_data", if_r.out_data, 0);
        check("rst_idx", if_r.out_idx, 0);
        check("rst_last", if_r.out_last, 0);
        check("rst_count", cnt_r, 0);
        check("rst_c_valid", if_c.out_valid, 0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", if_r.in_ready, 1);

        // Basic stream: {10,-5,100,0} + {1,1,1,-3}
        if_r.out_ready = 1'b1;
        log_r.delete(); log_n.delete();
        send_vec({8'd0, 8'd100, 8'hFB, 8'd10}, {8'hFD, 8'd1, 8'd1, 8'd1});
        if_r.in_valid = 1'b0;
        wait_cycles(6);
        check("basic_len", log_r.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("basic_r", (i < log_r.size()) ? log_r[i] : 999, exp_basic_r[i]);
            check("basic_n", (i < log_n.size()) ? log_n[i] : 999, exp_basic_n[i]);
        end
        check("basic_count", cnt_r, 1);

        // Saturation: 120+20 and -120-20
        log_r.delete(); log_n.delete();
        send_vec({8'd0, 8'd0, 8'h88, 8'd120}, {8'd0, 8'd0, 8'hEC, 8'd20});
        if_r.in_valid = 1'b0;
        wait_cycles(6);
        check("sat_len", log_r.size(), 4);
        check("sat_r0", (log_r.size() > 0) ? log_r[0] : 999, 127);
        check("sat_r1", (log_r.size() > 1) ? log_r[1] : 999, 0);
        check("sat_n0", (log_n.size() > 0) ? log_n[0] : 999, 127);
        check("sat_n1", (log_n.size() > 1) ? log_n[1] : 999, -128);

        // Backpressure pattern 1,0,0,1,0,1,1
        log_r.delete(); log_n.delete();
        send_vec(rand_vec(), rand_vec());
        if_r.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if_r.out_ready = pat[i];
            wait_cycles(1);
        end
        if_r.out_ready = 1'b1;
        wait_cycles(3);
        check("bp_len", log_r.size(), 4);
        check("bp_count", cnt_r, 3);

        // Back-to-back vectors with in_valid held high
        log_r.delete(); log_n.delete();
        send_vec(rand_vec(), rand_vec());
        send_vec(rand_vec(), rand_vec());
        if_r.in_valid = 1'b0;
        wait_cycles(10);
        check("b2b_len", log_r.size(), 8);
        check("b2b_count", cnt_r, 5);

        // Reset in the middle of a vector
        send_vec(rand_vec(), rand_vec());
        if_r.in_valid = 1'b0;
        wait_cycles(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", if_r.out_valid, 0);
        check("mid_rst_data", if_r.out_data, 0);
        check("mid_rst_idx", if_r.out_idx, 0);
        check("mid_rst_count", cnt_r, 0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", if_r.in_ready, 1);
        wait_cycles(1);
        log_r.delete(); log_n.delete();
        send_vec(rand_vec(), rand_vec());
        if_r.in_valid = 1'b0;
        wait_cycles(6);
        check("post_rst_len", log_r.size(), 4);
        check("post_rst_count", cnt_r, 1);

        // Random traffic and backpressure
        rdy_mode = 1;
        for (int v = 0; v < 40; v++) begin
            if_r.in_valid = 1'b0;
            wait_cycles($urandom_range(0, 2));
            send_vec(rand_vec(), rand_vec());
        end
        if_r.in_valid = 1'b0;
        rdy_mode = 0;
        if_r.out_ready = 1'b1;
        wait_cycles(10);
        check("rand_drained", exp_q.size(), 0);
        check("rand_count", cnt_r, 41);

        // OUT_DIM=1: 65537 vectors back to back, count wraps to 1
        if_c.out_ready = 1'b1;
        for (int v = 0; v < 65537; v++) begin
            send_c(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end
        if_c.in_valid = 1'b0;
        wait_cycles(3);
        check("wrap_count", cnt_c, 1);
        check("wrap_idle", if_c.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
